id_stage: RTL
=============

ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 Parameters SHALL be: REG_ADDR_WIDTH, 5, register index width; REG_DATA_WIDTH, 32, register data width.
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_valid  in  1  fetch offers an instruction.
- if_inst  in  32  instruction word.
- if_pc  in  32  instruction address.
- id_ready  out  1  stage accepts the instruction this cycle.
- flush  in  1  squash the held and the incoming instruction.
- raddr1 / raddr2  out  REG_ADDR_WIDTH  register-file read addresses (rs / rt).
- re1 / re2  out  1  register-file read enables.
- rdata1 / rdata2  in  REG_DATA_WIDTH  register-file read data, combinational.
- mem_we  in  1  MEM stage will write a register.
- mem_waddr  in  REG_ADDR_WIDTH  MEM destination.
- mem_wdata  in  REG_DATA_WIDTH  MEM result.
- mem_data_ok  in  1  mem_wdata is final (not a pending load).
- ex_valid  out  1  EX register holds an instruction.
- ex_ready  in  1  EX consumes it this cycle.
- ex_pc  out  32; ex_op  out  6; ex_funct  out  6; ex_shamt  out  5.
- ex_src1 / ex_src2  out  REG_DATA_WIDTH  operand values.
- ex_imm  out  32  extended immediate.
- ex_waddr  out  REG_ADDR_WIDTH; ex_we  out  1; ex_is_load  out  1; ex_is_store  out  1; ex_illegal  out  1.

Function
REQ-003 Decode SHALL be combinational from if_inst; rs=[25:21], rt=[20:16], rd=[15:11].
- op 0x00 (R-type): re1=re2=1, waddr=rd, we=1.
- 0x08/0x09/0x0C/0x0D/0x0E: re1=1, re2=0, waddr=rt, we=1.
- 0x0F (LUI): re1=re2=0, waddr=rt, we=1.
- 0x23 (LW): re1=1, waddr=rt, we=1, is_load=1.
- 0x2B (SW): re1=re2=1, we=0, is_store=1.
- Any other op: re1=re2=0, we=0, illegal=1.
REQ-004 ex_imm SHALL be sign-extended for 0x08/0x09/0x23/0x2B, zero-extended for 0x0C/0x0D/0x0E, {imm,16'h0} for 0x0F, 0 otherwise.
REQ-005 re1/re2/raddr1/raddr2 SHALL be driven only when if_valid=1; otherwise re1=re2=0 and raddr1=raddr2=0.
REQ-006 A read SHALL hazard when its enable is 1, its address is non-zero, and it equals ex_waddr with ex_valid&ex_we=1, or equals mem_waddr with mem_we=1.
REQ-007 hold = ex_valid & ~ex_ready; stall = if_valid & any hazard not resolved per REQ-016; id_ready = ~hold & ~stall & ~flush.
REQ-008 On a rising edge with ~hold: if if_valid&id_ready, the EX register SHALL load the decoded instruction with ex_valid=1; otherwise ex_valid SHALL become 0 (bubble).
REQ-009 While hold=1, all ex_* outputs SHALL keep their values.
REQ-010 flush=1 SHALL force ex_valid to 0 on the next edge regardless of hold, and the incoming instruction SHALL NOT be accepted.
REQ-011 Operand fields of an unenabled read SHALL be 0; ex_src2 of an I-type SHALL be 0.
REQ-012 Latency SHALL be exactly one cycle from acceptance to ex_valid=1 when unstalled; throughput SHALL be one instruction per cycle.
REQ-013 Register 0 SHALL never cause a hazard or a forward.

Reset
REQ-014 While rst=1, ex_valid, ex_we, ex_is_load, ex_is_store and ex_illegal SHALL be 0 and all other ex_* SHALL be 0, asynchronously.
REQ-015 Reset asserted mid-stall or mid-hold SHALL discard the held instruction; the first edge after release SHALL be able to accept a new instruction.

Configuration
REQ-016 Macro ID_FWD_EN: when defined, a MEM-stage match with mem_data_ok=1 SHALL NOT stall and SHALL substitute mem_wdata for rdata1/rdata2; an EX-register match or a MEM match with mem_data_ok=0 SHALL still stall. When undefined, every REQ-006 hazard SHALL stall and no forwarding logic SHALL exist.

Verification
REQ-017 ADDI $2,$1,-1 (0x2022FFFF) with no hazards -> next cycle ex_valid=1, ex_waddr=2, ex_imm=0xFFFFFFFF, ex_src1=rdata1.
REQ-018 Load-use: LW $3 is in EX, then ADD $4,$3,$3 -> id_ready=0 and one bubble (ex_valid=0); ADD is accepted when the hazard clears.
REQ-019 With ID_FWD_EN: mem_we=1, mem_waddr=5, mem_wdata=0x1234, mem_data_ok=1, OR $6,$5,$0 -> no stall, ex_src1=0x1234.
REQ-020 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, id_ready=0, if_inst not consumed.
REQ-021 flush=1 while hold=1 -> ex_valid=0 on the next edge; if_valid instruction not accepted.
REQ-022 rst pulse during stall -> ex_valid=0 immediately; op 0x3F after release -> ex_illegal=1, ex_we=0.

Source files
------------

// File: rtl/id_stage.sv
// Instruction decode stage: decodes the fetched word, reads operands, detects
// RAW hazards against EX/MEM, and loads the EX pipeline register.
// Optional feature macro: ID_FWD_EN (forward final MEM results instead of stalling).
module id_stage #(
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned REG_DATA_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      if_valid,
  input  logic [31:0]               if_inst,
  input  logic [31:0]               if_pc,
  output logic                      id_ready,
  input  logic                      flush,
  output logic [REG_ADDR_WIDTH-1:0] raddr1,
  output logic [REG_ADDR_WIDTH-1:0] raddr2,
  output logic                      re1,
  output logic                      re2,
  input  logic [REG_DATA_WIDTH-1:0] rdata1,
  input  logic [REG_DATA_WIDTH-1:0] rdata2,
  input  logic                      mem_we,
  input  logic [REG_ADDR_WIDTH-1:0] mem_waddr,
  input  logic [REG_DATA_WIDTH-1:0] mem_wdata,
  input  logic                      mem_data_ok,
  output logic                      ex_valid,
  input  logic                      ex_ready,
  output logic [31:0]               ex_pc,
  output logic [5:0]                ex_op,
  output logic [5:0]                ex_funct,
  output logic [4:0]                ex_shamt,
  output logic [REG_DATA_WIDTH-1:0] ex_src1,
  output logic [REG_DATA_WIDTH-1:0] ex_src2,
  output logic [31:0]               ex_imm,
  output logic [REG_ADDR_WIDTH-1:0] ex_waddr,
  output logic                      ex_we,
  output logic                      ex_is_load,
  output logic                      ex_is_store,
  output logic                      ex_illegal
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef struct packed {
    logic [31:0]               pc;
    logic [5:0]                op;
    logic [5:0]                funct;
    logic [4:0]                shamt;
    logic [REG_DATA_WIDTH-1:0] src1;
    logic [REG_DATA_WIDTH-1:0] src2;
    logic [31:0]               imm;
    logic [REG_ADDR_WIDTH-1:0] waddr;
    logic                      we;
    logic                      is_load;
    logic                      is_store;
    logic                      illegal;
  } ex_pkt_t;

  logic [5:0]                op;
  logic [4:0]                rs, rt, rd;
  logic [15:0]               imm16;
  logic                      dec_re1, dec_re2;
  logic [REG_DATA_WIDTH-1:0] opnd1, opnd2;
  logic                      stall1, stall2;
  logic                      hold, stall;
  ex_pkt_t                   dec;
  ex_pkt_t                   ex_q;

  assign op    = if_inst[31:26];
  assign rs    = if_inst[25:21];
  assign rt    = if_inst[20:16];
  assign rd    = if_inst[15:11];
  assign imm16 = if_inst[15:0];

  // Field decode of the incoming instruction (operands filled in below)
  always_comb begin
    dec_re1        = 1'b0;
    dec_re2        = 1'b0;
    dec            = '0;
    dec.pc         = if_pc;
    dec.op         = op;
    dec.funct      = if_inst[5:0];
    dec.shamt      = if_inst[10:6];
    unique case (op)
      OP_RTYPE: begin
        dec_re1 = 1'b1; dec_re2 = 1'b1;
        dec.waddr = REG_ADDR_WIDTH'(rd); dec.we = 1'b1;
      end
      OP_ADDI, OP_ADDIU: begin
        dec_re1 = 1'b1;
        dec.waddr = REG_ADDR_WIDTH'(rt); dec.we = 1'b1;
        dec.imm = {{16{imm16[15]}}, imm16};
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        dec_re1 = 1'b1;
        dec.waddr = REG_ADDR_WIDTH'(rt); dec.we = 1'b1;
        dec.imm = {16'h0000, imm16};
      end
      OP_LUI: begin
        dec.waddr = REG_ADDR_WIDTH'(rt); dec.we = 1'b1;
        dec.imm = {imm16, 16'h0000};
      end
      OP_LW: begin
        dec_re1 = 1'b1;
        dec.waddr = REG_ADDR_WIDTH'(rt); dec.we = 1'b1; dec.is_load = 1'b1;
        dec.imm = {{16{imm16[15]}}, imm16};
      end
      OP_SW: begin
        dec_re1 = 1'b1; dec_re2 = 1'b1; dec.is_store = 1'b1;
        dec.imm = {{16{imm16[15]}}, imm16};
      end
      default: dec.illegal = 1'b1;
    endcase
    dec.src1 = re1 ? opnd1 : '0;
    dec.src2 = re2 ? opnd2 : '0;
  end

  // Register-file read port: quiet when fetch has nothing to offer
  always_comb begin
    re1    = if_valid & dec_re1;
    re2    = if_valid & dec_re2;
    raddr1 = if_valid ? REG_ADDR_WIDTH'(rs) : '0;
    raddr2 = if_valid ? REG_ADDR_WIDTH'(rt) : '0;
  end

  // RAW hazard detection and operand selection; register 0 never matches
  logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
  assign ex_hit1  = re1 & (raddr1 != '0) & ex_valid & ex_we & (raddr1 == ex_waddr);
  assign ex_hit2  = re2 & (raddr2 != '0) & ex_valid & ex_we & (raddr2 == ex_waddr);
  assign mem_hit1 = re1 & (raddr1 != '0) & mem_we & (raddr1 == mem_waddr);
  assign mem_hit2 = re2 & (raddr2 != '0) & mem_we & (raddr2 == mem_waddr);

`ifdef ID_FWD_EN
  // A final MEM result is bypassed; a pending load still has to wait
  always_comb begin
    stall1 = ex_hit1 | (mem_hit1 & ~mem_data_ok);
    stall2 = ex_hit2 | (mem_hit2 & ~mem_data_ok);
    opnd1  = (mem_hit1 & mem_data_ok) ? mem_wdata : rdata1;
    opnd2  = (mem_hit2 & mem_data_ok) ? mem_wdata : rdata2;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{mem_data_ok, mem_wdata};

  // Without bypassing, every in-flight producer stalls the consumer
  always_comb begin
    stall1 = ex_hit1 | mem_hit1;
    stall2 = ex_hit2 | mem_hit2;
    opnd1  = rdata1;
    opnd2  = rdata2;
  end
`endif

  assign hold     = ex_valid & ~ex_ready;
  assign stall    = if_valid & (stall1 | stall2);
  assign id_ready = ~hold & ~stall & ~flush;

  // EX pipeline register: load, bubble, hold, or squash
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid <= 1'b0;
      ex_q     <= '0;
    end else if (flush | ~hold) begin
      if (if_valid & id_ready) begin
        ex_valid <= 1'b1;
        ex_q     <= dec;
      end else begin
        ex_valid      <= 1'b0;
        ex_q.we       <= 1'b0;
        ex_q.is_load  <= 1'b0;
        ex_q.is_store <= 1'b0;
        ex_q.illegal  <= 1'b0;
      end
    end
  end

  assign ex_pc       = ex_q.pc;
  assign ex_op       = ex_q.op;
  assign ex_funct    = ex_q.funct;
  assign ex_shamt    = ex_q.shamt;
  assign ex_src1     = ex_q.src1;
  assign ex_src2     = ex_q.src2;
  assign ex_imm      = ex_q.imm;
  assign ex_waddr    = ex_q.waddr;
  assign ex_we       = ex_q.we;
  assign ex_is_load  = ex_q.is_load;
  assign ex_is_store = ex_q.is_store;
  assign ex_illegal  = ex_q.illegal;

endmodule
